// File: rtl/gshare_pht.sv
// gshare_pht -- pattern history table and global history register for a
// gshare branch predictor.
//
// Fetch side: index = PC[PC_LSB +: PHT_BITS] xor zero-extended GHR. The
// 2-bit counter at that index is read and the prediction is registered, so
// it appears one cycle after the lookup. The predicted direction is shifted
// into the GHR speculatively in the same cycle as the lookup.
// Resolve side: saturating read-modify-write of the counter at the index
// carried down the pipe. On a misprediction the GHR is rebuilt from the
// snapshot carried with the branch plus the real outcome.
//
// After reset the table is filled with 2'b01 (weakly not taken), one entry
// per cycle. Requests are ignored until the fill is complete.
//
// Handshake: there is no backpressure. o_ready high means every lookup and
// update presented in that cycle is accepted; o_ready low means they are
// dropped. o_pred_valid is a one-cycle strobe marking the pred outputs as
// belonging to the lookup accepted in the previous cycle; the other pred
// outputs hold their last value while it is low.
//
// Build option: define GSHARE_PHT_BYPASS_EN to forward the post-update
// counter to a same-cycle lookup of the same index. Without it the lookup
// sees the counter as it was before the update (read-before-write).
//
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_lookup_en/pc    fetch lookup request and branch PC
//   o_pred_valid      prediction strobe (one cycle after accepted lookup)
//   o_pred_taken      predicted direction (counter bit 1)
//   o_pred_idx        table index used, carried to the update
//   o_pred_ghr        GHR before this lookup's shift (recovery snapshot)
//   i_upd_en/idx/taken/mispred/ghr  resolved branch update
//   o_ready           table initialised
//   o_dbg_state       FSM state (0 = INIT, 1 = RUN)

module gshare_pht #(
   parameter int PHT_BITS = 8,
   parameter int GHR_BITS = 8,
   parameter int PC_LSB   = 2
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_lookup_en,
   input  logic [31:0]         i_lookup_pc,
   output logic                o_pred_valid,
   output logic                o_pred_taken,
   output logic [PHT_BITS-1:0] o_pred_idx,
   output logic [GHR_BITS-1:0] o_pred_ghr,
   input  logic                i_upd_en,
   input  logic [PHT_BITS-1:0] i_upd_idx,
   input  logic                i_upd_taken,
   input  logic                i_upd_mispred,
   input  logic [GHR_BITS-1:0] i_upd_ghr,
   output logic                o_ready,
   output logic [0:0]          o_dbg_state
);

   localparam int ENTRIES = 1 << PHT_BITS;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]          state;
   logic [PHT_BITS-1:0] init_ptr;
   logic [GHR_BITS-1:0] ghr;
   logic [1:0]          pht [0:ENTRIES-1];

   logic                lk_fire;
   logic                upd_fire;
   logic [PHT_BITS-1:0] ghr_ext;
   logic [PHT_BITS-1:0] lk_idx;
   logic [1:0]          lk_ctr;
   logic                lk_bit;
   logic [1:0]          upd_old;
   logic [1:0]          upd_new;

   // Requests only count once the table is filled.
   assign lk_fire  = (state == ST_RUN) && i_lookup_en;
   assign upd_fire = (state == ST_RUN) && i_upd_en;

   // GHR occupies the low bits of the index; upper bits come from PC only.
   always_comb begin
      ghr_ext = '0;
      ghr_ext[GHR_BITS-1:0] = ghr;
   end

   assign lk_idx = i_lookup_pc[PC_LSB +: PHT_BITS] ^ ghr_ext;

   // Saturating 2-bit counter step.
   always_comb begin
      upd_old = pht[i_upd_idx];
      upd_new = upd_old;
      if (i_upd_taken) begin
         if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
      end else begin
         if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
      end
   end

   always_comb begin
      lk_ctr = pht[lk_idx];
`ifdef GSHARE_PHT_BYPASS_EN
      if (upd_fire && (i_upd_idx == lk_idx)) lk_ctr = upd_new;
`endif
      lk_bit = lk_ctr[1];
   end

   // Init sequencer: one entry per cycle, RUN once the last entry is written.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= ST_INIT;
         init_ptr <= '0;
      end else if (state == ST_INIT) begin
         init_ptr <= init_ptr + PHT_BITS'(1);
         if (&init_ptr) state <= ST_RUN;
      end
   end

   // Counter storage. Not reset directly: the INIT sweep clears it.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         if (state == ST_INIT) begin
            pht[init_ptr] <= 2'b01;
         end else if (i_upd_en) begin
            pht[i_upd_idx] <= upd_new;
         end
      end
   end

   // Global history. Mispredict recovery outranks the speculative shift of a
   // same-cycle lookup; that lookup still reports the pre-recovery GHR.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ghr <= '0;
      end else if (upd_fire && i_upd_mispred) begin
         ghr <= {i_upd_ghr[GHR_BITS-2:0], i_upd_taken};
      end else if (lk_fire) begin
         ghr <= {ghr[GHR_BITS-2:0], lk_bit};
      end
   end

   // Registered prediction; payload holds when no lookup was accepted.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_pred_valid <= 1'b0;
         o_pred_taken <= 1'b0;
         o_pred_idx   <= '0;
         o_pred_ghr   <= '0;
      end else begin
         o_pred_valid <= lk_fire;
         if (lk_fire) begin
            o_pred_taken <= lk_bit;
            o_pred_idx   <= lk_idx;
            o_pred_ghr   <= ghr;
         end
      end
   end

   assign o_ready     = (state == ST_RUN);
   assign o_dbg_state = state;

   // PC bits outside the index window and the GHR bit shifted out on
   // recovery are architecturally irrelevant here.
   logic unused_bits;
   assign unused_bits = ^{i_lookup_pc[31:PC_LSB+PHT_BITS],
                          i_lookup_pc[PC_LSB-1:0],
                          i_upd_ghr[GHR_BITS-1],
                          lk_ctr[0]};

endmodule

// File: tb/tb_gshare_pht.sv
module tb_gshare_pht;

   logic        clk = 1'b0;
   logic        rst;
   logic        lookup_en;
   logic [31:0] lookup_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic [7:0]  pred_idx;
   logic [7:0]  pred_ghr;
   logic        upd_en;
   logic [7:0]  upd_idx;
   logic        upd_taken;
   logic        upd_mispred;
   logic [7:0]  upd_ghr;
   logic        ready;
   logic [0:0]  dbg_state;

`ifdef GSHARE_PHT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   logic [1:0]  mpht [256];
   logic [7:0]  mghr;
   logic [16:0] exp_q [$];     // {taken, idx[7:0], ghr[7:0]}
   logic [16:0] last_exp;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   gshare_pht dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_lookup_en   (lookup_en),
      .i_lookup_pc   (lookup_pc),
      .o_pred_valid  (pred_valid),
      .o_pred_taken  (pred_taken),
      .o_pred_idx    (pred_idx),
      .o_pred_ghr    (pred_ghr),
      .i_upd_en      (upd_en),
      .i_upd_idx     (upd_idx),
      .i_upd_taken   (upd_taken),
      .i_upd_mispred (upd_mispred),
      .i_upd_ghr     (upd_ghr),
      .o_ready       (ready),
      .o_dbg_state   (dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
      if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
      else   return (c == 2'b00) ? 2'b00 : c - 2'd1;
   endfunction

   // PC whose index maps to idx under the current model GHR.
   function automatic logic [31:0] pc_for(input logic [7:0] idx);
      return {22'd0, idx ^ mghr, 2'b00};
   endfunction

   task automatic drive_idle();
      lookup_en   = 1'b0;
      lookup_pc   = '0;
      upd_en      = 1'b0;
      upd_idx     = '0;
      upd_taken   = 1'b0;
      upd_mispred = 1'b0;
      upd_ghr     = '0;
   endtask

   // ---------------- driver + scoreboard step ----------------
   task automatic step(input logic lk, input logic [31:0] pc, input logic up,
                       input logic [7:0] uidx, input logic ut, input logic um,
                       input logic [7:0] ug);
      logic [7:0]  li;
      logic [1:0]  c;
      logic        b;
      logic [16:0] e;
      li = pc[9:2] ^ mghr;
      c  = mpht[li];
      if (BYP && up && (uidx == li)) c = sat(mpht[uidx], ut);
      b = c[1];
      lookup_en   = lk;
      lookup_pc   = pc;
      upd_en      = up;
      upd_idx     = uidx;
      upd_taken   = ut;
      upd_mispred = um;
      upd_ghr     = ug;
      if (lk) exp_q.push_back({b, li, mghr});
      if (up) mpht[uidx] = sat(mpht[uidx], ut);
      if (up && um)  mghr = {ug[6:0], ut};
      else if (lk)   mghr = {mghr[6:0], b};
      tick();
      drive_idle();
      if (lk) begin
         chk("pred_valid", pred_valid, 1);
         if (exp_q.size() == 0) begin
            chk("exp_q_nonempty", 0, 1);
         end else begin
            e = exp_q.pop_front();
            chk("pred_taken", pred_taken, e[16]);
            chk("pred_idx", pred_idx, e[15:8]);
            chk("pred_ghr", pred_ghr, e[7:0]);
            last_exp = e;
         end
      end else begin
         chk("pred_valid_idle", pred_valid, 0);
         chk("hold_taken", pred_taken, last_exp[16]);
         chk("hold_idx", pred_idx, last_exp[15:8]);
         chk("hold_ghr", pred_ghr, last_exp[7:0]);
      end
   endtask

   // Random requests while the table is filling; all must be ignored.
   task automatic init_noise(input int cycles, output logic saw_valid);
      saw_valid = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         lookup_en   = 1'($urandom_range(0, 1));
         lookup_pc   = $urandom;
         upd_en      = 1'($urandom_range(0, 1));
         upd_idx     = (i % 3 == 0) ? 8'h10 : (i % 3 == 1) ? 8'h22 : 8'h30;
         upd_taken   = 1'b1;
         upd_mispred = 1'($urandom_range(0, 1));
         upd_ghr     = 8'($urandom);
         tick();
         if (pred_valid) saw_valid = 1'b1;
      end
      drive_idle();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic saw_valid;
      int   cyc;
      for (int i = 0; i < 256; i++) mpht[i] = 2'b01;
      mghr     = '0;
      last_exp = '0;
      drive_idle();

      // Reset state.
      rst = 1'b1;
      tick();
      chk("rst_ready", ready, 0);
      chk("rst_valid", pred_valid, 0);
      chk("rst_taken", pred_taken, 0);
      chk("rst_idx", pred_idx, 0);
      chk("rst_ghr", pred_ghr, 0);
      chk("rst_state", dbg_state, 0);
      rst = 1'b0;

      // Partial INIT, then reset at pointer 100.
      init_noise(100, saw_valid);
      chk("init_part_ready", ready, 0);
      chk("init_part_novalid", saw_valid, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rerst_ready", ready, 0);

      // Full INIT from pointer 0 with ignored traffic.
      saw_valid = 1'b0;
      cyc = 0;
      while (cyc < 300) begin
         lookup_en   = 1'($urandom_range(0, 1));
         lookup_pc   = $urandom;
         upd_en      = 1'($urandom_range(0, 1));
         upd_idx     = (cyc % 2 == 0) ? 8'h10 : 8'h22;
         upd_taken   = 1'b1;
         upd_mispred = 1'($urandom_range(0, 1));
         upd_ghr     = 8'($urandom);
         tick();
         cyc++;
         if (pred_valid) saw_valid = 1'b1;
         if (ready) break;
      end
      drive_idle();
      chk("init_cycles", cyc, 256);
      chk("init_ready", ready, 1);
      chk("init_novalid", saw_valid, 0);
      chk("run_state", dbg_state, 1);

      // First lookup: PC 0x40, GHR 0 -> idx 0x10, not taken.
      step(1, 32'h0000_0040, 0, 0, 0, 0, 0);
      chk("first_idx", pred_idx, 8'h10);
      chk("first_taken", pred_taken, 0);
      chk("first_ghr", pred_ghr, 8'h00);
      step(0, 0, 0, 0, 0, 0, 0);

      // Counter saturation at idx 0x10.
      for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h10, 1, 0, 0);
      step(1, pc_for(8'h10), 0, 0, 0, 0, 0);
      chk("sat_st_taken", pred_taken, 1);
      step(0, 0, 1, 8'h10, 1, 0, 0);
      step(1, pc_for(8'h10), 0, 0, 0, 0, 0);
      chk("sat_hold_taken", pred_taken, 1);
      step(0, 0, 1, 8'h10, 0, 0, 0);
      step(0, 0, 1, 8'h10, 0, 0, 0);
      step(1, pc_for(8'h10), 0, 0, 0, 0, 0);
      chk("wnt_taken", pred_taken, 0);

      // GHR = 0xA5 via recovery (also bumps idx 0x30 to 10).
      step(0, 0, 1, 8'h30, 1, 1, 8'h52);
      step(1, pc_for(8'h30), 0, 0, 0, 0, 0);
      chk("ghr_a5", pred_ghr, 8'hA5);
      chk("ghr_a5_taken", pred_taken, 1);
      // GHR now 0x4B; same-cycle lookup + mispredict recovery.
      step(1, pc_for(8'h30), 1, 8'h40, 0, 1, 8'h3C);
      chk("ghr_4b", pred_ghr, 8'h4B);
      step(1, pc_for(8'h55), 0, 0, 0, 0, 0);
      chk("ghr_78", pred_ghr, 8'h78);

      // Mispred flag without update enable is ignored.
      step(1, pc_for(8'h01), 0, 0, 1, 1, 8'hFF);
      step(1, pc_for(8'h02), 0, 0, 0, 0, 0);

      // Same-cycle lookup and update collision at idx 0x22.
      step(1, pc_for(8'h22), 1, 8'h22, 1, 0, 0);
      chk("collide_taken", pred_taken, BYP ? 1 : 0);
      step(1, pc_for(8'h22), 0, 0, 0, 0, 0);
      chk("collide_after", pred_taken, 1);

      // Random traffic over a small index set to provoke collisions.
      for (int i = 0; i < 80; i++) begin
         logic        lk;
         logic [31:0] pc;
         lk = 1'($urandom_range(0, 1));
         pc = pc_for(8'($urandom_range(0, 7)));
         step(lk, pc, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      end

      chk("exp_q_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Pattern history table and global history register for the gshare predictor.
- Lookup side (fetch): forms index = PC xor GHR, returns the registered 2-bit counter prediction, and shifts the predicted direction into the GHR speculatively.
- Update side (branch resolve): read-modify-writes the saturating counter at the carried index, and restores the GHR on a misprediction.
- This block stores the counters and drives the fetch stage.

Parameters:
- PHT_BITS, 8, log2 of table entries (256 x 2-bit counters).
- GHR_BITS, 8, global history length; must be <= PHT_BITS.
- PC_LSB, 2, lowest PC bit used in the index (word-aligned instructions).

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous active-high reset
- i_lookup_en  input  1  fetch has a branch; perform lookup
- i_lookup_pc  input  32  PC of the fetched branch
- o_pred_valid  output  1  prediction outputs valid (one cycle after accepted lookup)
- o_pred_taken  output  1  predicted direction (counter bit 1)
- o_pred_idx  output  PHT_BITS  index used; carried down the pipe for update
- o_pred_ghr  output  GHR_BITS  GHR value before this lookup's shift (recovery snapshot)
- i_upd_en  input  1  resolved branch update
- i_upd_idx  input  PHT_BITS  index carried from o_pred_idx
- i_upd_taken  input  1  actual outcome
- i_upd_mispred  input  1  prediction was wrong
- i_upd_ghr  input  GHR_BITS  snapshot carried from o_pred_ghr
- o_ready  output  1  table initialised; lookups/updates accepted

Behaviour:
- Reset (synchronous, active-high) values:
  - FSM enters INIT; init pointer = 0.
  - GHR = 0.
  - o_ready = 0, o_pred_valid = 0, o_pred_taken = 0, o_pred_idx = 0, o_pred_ghr = 0.
- FSM INIT:
  - Writes 2'b01 (weakly not taken) to entry[pointer] each cycle, then increments the pointer.
  - After writing entry 2^PHT_BITS-1, the FSM moves to RUN and o_ready = 1 next cycle. INIT takes exactly 2^PHT_BITS cycles.
  - In INIT, i_lookup_en and i_upd_en are ignored: no GHR change, no table write, o_pred_valid = 0.
  - Reset asserted mid-INIT restarts INIT from pointer 0.
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Index: i_lookup_pc[PC_LSB+PHT_BITS-1:PC_LSB] xor zero-extended GHR (GHR in the low bits).
- Lookup (RUN, i_lookup_en = 1), registered with 1-cycle latency. Next cycle:
  - o_pred_valid = 1, o_pred_taken = entry[idx][1], o_pred_idx = idx, o_pred_ghr = GHR at lookup.
  - o_pred_valid = 0 in any cycle after no lookup; other pred outputs hold their last value.
- Speculative GHR on lookup: GHR <= {GHR[GHR_BITS-2:0], entry[idx][1]}.
- Update (RUN, i_upd_en = 1), saturating read-modify-write of entry[i_upd_idx], written at the clock edge:
  - taken: 00->01->10->11, 11 stays 11.
  - not taken: 11->10->01->00, 00 stays 00.
- Misprediction (i_upd_en & i_upd_mispred): GHR <= {i_upd_ghr[GHR_BITS-2:0], i_upd_taken}.
- Simultaneous events:
  - Mispredict recovery has priority over a same-cycle lookup GHR shift; that lookup's prediction is still produced, using the pre-recovery GHR.
  - i_upd_mispred without i_upd_en is ignored.
  - Lookup and update to the same index in the same cycle: the lookup reads the old counter (read-before-write) unless the optional feature is enabled.
- No backpressure: every RUN-cycle request is accepted.

Optional Feature:
- Macro GSHARE_PHT_BYPASS_EN.
- Defined: a same-cycle lookup/update index collision forwards the post-update counter value to o_pred_taken and to the speculative GHR shift.
- Undefined: read-before-write; the old counter is used.

Test Plan:
- Reset held 1 cycle, then released -> o_ready = 0 for 256 cycles and rises on cycle 256; a lookup at any PC then returns o_pred_taken = 0 (counter 01).
- Lookup PC = 0x0000_0040 with GHR = 0 -> next cycle o_pred_valid = 1, o_pred_idx = 0x10, o_pred_ghr = 0x00; GHR becomes 0x00.
- Update idx 0x10 taken 3 times, then lookup mapping to 0x10 -> o_pred_taken = 1 (counter 11); a 4th taken update keeps 11; 2 not-taken updates -> counter 01, prediction 0.
- GHR = 0xA5; lookup shifts in 1 -> GHR = 0x4B; same-cycle lookup + mispred update with i_upd_ghr = 0x3C, i_upd_taken = 0 -> GHR = 0x78 (recovery wins).
- Same-cycle lookup and update to idx 0x22 (counter 01, taken) -> o_pred_taken = 0 without GSHARE_PHT_BYPASS_EN, 1 with it; counter = 10 afterwards in both builds.
- Reset asserted at INIT pointer 100 -> INIT restarts at 0; o_ready rises 256 cycles after reset release; lookups/updates issued during INIT cause no GHR or table change.
